// File: rtl/wfload_pkg.sv
// wfload_pkg: shared state/error encodings and length field location for the waveform loader
package wfload_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_LOAD, S_DONE} state_t;
  typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_BAD_LEN = 2'd1, ERR_ABORT = 2'd2, ERR_TIMEOUT = 2'd3} err_t;
  localparam int LEN_FIELD_LSB = 0;
  localparam int LEN_FIELD_MSB = 31;
endpackage

// File: rtl/wfload_timeout_ctr.sv
// wfload_timeout_ctr: idle-cycle counter; expire rises on the (TIMEOUT_CYCLES-1)th cycle after the last clear
module wfload_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expire
);
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam int W = $clog2(TIMEOUT_CYCLES + 1);
      logic [W-1:0] cnt_q, cnt_d;
      // cnt counts edges since the last clear, so a beat at cycle t aborts at cycle t+TIMEOUT_CYCLES
      always_comb cnt_d = clr ? W'(1) : (cnt_q == W'(TIMEOUT_CYCLES) ? cnt_q : cnt_q + W'(1));
      always_ff @(posedge clk)
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
      assign expire = !clr && (cnt_q >= W'(TIMEOUT_CYCLES - 1));
    end
  endgenerate
endmodule

// File: rtl/waveform_loader.sv
// waveform_loader: streams formatter words into the waveform RAM and reports done/valid/errors.
// Optional running checksum of loaded words enabled by WFLOAD_CHECKSUM_EN.
module waveform_loader
  import wfload_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  axi_tclk,
  input  logic                  axi_treset,
  input  logic                  init_wf_write,
  input  logic [127:0]          waveform_parameters,
  output logic                  wf_write_ready,
  input  logic [31:0]           s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [31:0]           s_axis_tuser,
  output logic                  s_axis_tready,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [31:0]           ram_wr_data,
  output logic                  wfrm_valid,
  output logic [31:0]           wfrm_len,
  output logic [31:0]           wfrm_checksum,
  output logic                  load_done,
  output logic                  load_error,
  output logic [1:0]            error_code,
  output logic [15:0]           stray_count
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [32:0] MAX_LEN = 33'(1) << ADDR_WIDTH;

  state_t state_q, state_d;
  err_t error_code_q, error_code_d;
  logic [31:0] len_q, len_d, wp_len, data_q, data_d, wfrm_len_q, wfrm_len_d;
  logic [CW-1:0] count_q, count_d, count_inc;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0] stray_q, stray_d;
  logic init_q, wr_en_q, wr_en_d, valid_q, valid_d, done_q, done_d, err_q, err_d;
  logic beat, load_beat, last, init_rise, bad_len, expire, tmo_clr, unused_ok;

  assign unused_ok = ^{waveform_parameters[127:LEN_FIELD_MSB+1], s_axis_tlast, s_axis_tuser};
  assign wp_len = waveform_parameters[LEN_FIELD_MSB:LEN_FIELD_LSB];
  assign s_axis_tready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign wf_write_ready = (state_q == S_IDLE);
  assign beat = s_axis_tvalid && s_axis_tready;
  assign load_beat = beat && (state_q == S_LOAD);
  assign count_inc = count_q + CW'(1);
  assign last = (32'(count_inc) == len_q);
  assign init_rise = init_wf_write && !init_q;
  assign bad_len = (wp_len == 32'd0) || ({1'b0, wp_len} > MAX_LEN);
  assign tmo_clr = (state_q != S_LOAD) || beat;

  wfload_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk(axi_tclk), .rst(axi_treset), .clr(tmo_clr), .expire(expire)
  );

  always_comb begin
    state_d = state_q;
    len_d = len_q;
    count_d = count_q;
    wr_en_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    valid_d = valid_q;
    wfrm_len_d = wfrm_len_q;
    done_d = 1'b0;
    err_d = 1'b0;
    error_code_d = error_code_q;
    stray_d = stray_q;
    case (state_q)
      S_IDLE: begin
        stray_d = (beat && stray_q != 16'hFFFF) ? stray_q + 16'd1 : stray_q;
        state_d = init_wf_write ? S_ARM : S_IDLE;
      end
      S_ARM: begin
        len_d = wp_len;
        valid_d = 1'b0;
        count_d = '0;
        addr_d = '0;
        error_code_d = bad_len ? ERR_BAD_LEN : ERR_NONE;
        err_d = bad_len;
        state_d = bad_len ? S_IDLE : S_LOAD;
      end
      S_LOAD: begin
        if (beat) begin
          wr_en_d = 1'b1;
          addr_d = count_q[ADDR_WIDTH-1:0];
          data_d = s_axis_tdata;
          count_d = count_inc;
        end
        // a completing beat outranks a concurrent abort or timeout
        if (beat && last) state_d = S_DONE;
        else if (init_rise || expire) begin
          state_d = S_IDLE;
          err_d = 1'b1;
          error_code_d = init_rise ? ERR_ABORT : ERR_TIMEOUT;
        end
      end
      default: begin
        done_d = 1'b1;
        valid_d = 1'b1;
        wfrm_len_d = len_q;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge axi_tclk) begin
    if (axi_treset) begin
      state_q <= S_IDLE;
      len_q <= '0;
      count_q <= '0;
      init_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      wfrm_len_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      error_code_q <= ERR_NONE;
      stray_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      count_q <= count_d;
      init_q <= init_wf_write;
      wr_en_q <= wr_en_d;
      addr_q <= addr_d;
      data_q <= data_d;
      valid_q <= valid_d;
      wfrm_len_q <= wfrm_len_d;
      done_q <= done_d;
      err_q <= err_d;
      error_code_q <= error_code_d;
      stray_q <= stray_d;
    end
  end

`ifdef WFLOAD_CHECKSUM_EN
  logic [31:0] sum_q, sum_d, cks_q, cks_d;
  always_comb begin
    sum_d = (state_q == S_ARM) ? 32'd0 : load_beat ? sum_q + s_axis_tdata : sum_q;
    cks_d = (state_q == S_ARM) ? 32'd0 : (state_q == S_DONE) ? sum_q : cks_q;
  end
  always_ff @(posedge axi_tclk) begin
    if (axi_treset) begin
      sum_q <= '0;
      cks_q <= '0;
    end else begin
      sum_q <= sum_d;
      cks_q <= cks_d;
    end
  end
  assign wfrm_checksum = cks_q;
`else
  logic unused_beat;
  assign unused_beat = load_beat;
  assign wfrm_checksum = 32'd0;
`endif

  assign ram_wr_en = wr_en_q;
  assign ram_wr_addr = addr_q;
  assign ram_wr_data = data_q;
  assign wfrm_valid = valid_q;
  assign wfrm_len = wfrm_len_q;
  assign load_done = done_q;
  assign load_error = err_q;
  assign error_code = error_code_q;
  assign stray_count = stray_q;
endmodule

// File: doc/waveform_loader.md
Name: waveform_loader

Overview:
- Downstream neighbour of the waveform command formatter.
- Takes its init_wf_write / waveform_parameters handshake and its 32-bit AXI-Stream payload.
- Writes the waveform words into a single-port-write waveform RAM, starting at address 0.
- Reports completion, validity and errors to the chirp playback logic. Returns wf_write_ready to the formatter.

Parameters:
- ADDR_WIDTH, 12, RAM address width; maximum waveform length is 2**ADDR_WIDTH words.
- TIMEOUT_CYCLES, 65535, idle cycles allowed between beats in LOAD before abort; 0 disables the timeout.

Ports:
- axi_tclk  in  1  sole clock
- axi_treset  in  1  synchronous, active-high reset
- init_wf_write  in  1  level request from formatter; held until wf_write_ready is seen
- waveform_parameters  in  128  [31:0] = waveform length in words; rest ignored
- wf_write_ready  out  1  loader idle, able to accept a new waveform
- s_axis_tdata  in  32  waveform word
- s_axis_tvalid  in  1  beat valid
- s_axis_tlast  in  1  packet boundary (informational only)
- s_axis_tuser  in  32  length echo from formatter
- s_axis_tready  out  1  beat accept
- ram_wr_en  out  1  RAM write strobe
- ram_wr_addr  out  ADDR_WIDTH  RAM write address
- ram_wr_data  out  32  RAM write data
- wfrm_valid  out  1  RAM holds a complete waveform
- wfrm_len  out  32  length of the valid waveform
- wfrm_checksum  out  32  see Optional Feature
- load_done  out  1  one-cycle pulse on completion
- load_error  out  1  one-cycle pulse on error
- error_code  out  2  1=BAD_LEN, 2=ABORT, 3=TIMEOUT; held until the next error or ARM
- stray_count  out  16  saturating count of beats discarded in IDLE

Behaviour:
- Reset values: all outputs 0 except wf_write_ready=1 and s_axis_tready=1 (IDLE); state IDLE; counters 0.

States:
- IDLE
  - wf_write_ready=1; s_axis_tready=1.
  - Accepted beats are discarded; stray_count increments and saturates at 16'hFFFF.
  - init_wf_write=1 -> ARM. The formatter drops init on the following cycle.
- ARM (1 cycle)
  - tready=0, wf_write_ready=0.
  - Latch len=waveform_parameters[31:0]; clear wfrm_valid, error_code, word counter, address and checksum.
  - len==0 or len>2**ADDR_WIDTH -> load_error pulse, error_code=1, IDLE.
  - Otherwise -> LOAD.
- LOAD
  - tready=1, wf_write_ready=0.
  - Each accepted beat (tvalid&tready) produces ram_wr_en=1, ram_wr_data=tdata, ram_wr_addr=count, registered on the next cycle; count increments.
  - s_axis_tlast does not end the load; a waveform may span several packets.
  - The beat that makes count==len -> DONE. Further beats are not accepted that cycle's successor.
  - Rising edge of init_wf_write (registered compare) -> load_error, error_code=2, IDLE. A new waveform supersedes the partial one; wfrm_valid stays 0.
  - Idle counter: reset on each accepted beat. Reaching TIMEOUT_CYCLES (when nonzero) -> load_error, error_code=3, IDLE.
  - If the final beat coincides with an init rising edge or a timeout, the final beat wins: DONE. A still-held init is then served from IDLE.
- DONE (1 cycle)
  - tready=0.
  - load_done=1; wfrm_valid=1; wfrm_len=len.
  - -> IDLE.

Other rules:
- Latency: accepted beat to RAM write is 1 cycle. Last beat to load_done is 2 cycles. load_done is coincident with nothing else; the last ram_wr_en precedes it by 1 cycle.
- s_axis_tuser != len on an accepted beat is ignored. The formatter is authoritative via waveform_parameters.
- Address arithmetic: count is ADDR_WIDTH+1 bits, so len=2**ADDR_WIDTH does not wrap before compare.
- Reset mid-LOAD: immediate return to IDLE, wfrm_valid=0, no pulses.

Optional Feature:
- Macro: WFLOAD_CHECKSUM_EN.
- Defined: 32-bit running sum (mod 2^32) of every word written in the current load. Registered into wfrm_checksum in DONE; cleared in ARM.
- Undefined: wfrm_checksum tied to 0; no adder is inferred.

Decomposition:
- Package wfload_pkg:
  - state encoding (IDLE/ARM/LOAD/DONE, 2 bits)
  - error codes ERR_NONE/ERR_BAD_LEN/ERR_ABORT/ERR_TIMEOUT
  - LEN_FIELD_LSB=0, LEN_FIELD_MSB=31
- Sub-module wfload_timeout_ctr: parameterised idle-cycle counter with clear and expire outputs; TIMEOUT_CYCLES=0 makes expire constant 0.

Test Plan:
- Reset, then init with len=8, then 8 beats with data 0x100..0x107 and tlast on beat 8 -> writes at addr 0..7 with matching data, load_done 2 cycles after last beat, wfrm_valid=1, wfrm_len=8, checksum=0x81C when enabled.
- len=6 delivered as 2 packets of 3 with tlast each, tvalid gaps of 5 cycles -> single load_done after beat 6, no error.
- len=0, then len=4097 with ADDR_WIDTH=12 -> load_error, error_code=1, no ram_wr_en, wf_write_ready returns next cycle.
- init len=10, 4 beats, then init deasserted and re-asserted -> error_code=2, wfrm_valid=0, next ARM latches the new length.
- TIMEOUT_CYCLES=16, len=4, 2 beats, then silence -> load_error with error_code=3 exactly 16 cycles after the last beat.
- 3 beats while IDLE with no init -> stray_count=3, no ram_wr_en. Reset asserted mid-LOAD -> all outputs at reset values on the next cycle.
